// File: rtl/sbtr_fault_rx_if.sv
// Scan/control bundle between an SBTR fault-frame source and its receiver.
interface sbtr_fault_rx_if #(
  parameter int SR_LEN = 8
);
  logic              EN;
  logic              SI;
  logic              DONE;
  logic              SO;
  logic [1:0]        FI_MODE;
  logic [SR_LEN-1:0] FMASK;
  logic              TFEn;
  logic              ERR;

  modport master (output EN, SI, DONE, input SO, FI_MODE, FMASK, TFEn, ERR);
  modport slave  (input EN, SI, DONE, output SO, FI_MODE, FMASK, TFEn, ERR);
endinterface

// File: rtl/sbtr_fault_rx.sv
// SBTR fault-frame receiver: deserialises {mode, timeout, mask} from SI/EN and
// times TFEn during the DONE window; SO forwards the stream to the next receiver.
//
// state   | meaning
// S_IDLE  | no frame activity since reset / last DONE window
// S_SHIFT | frame bits being (or having been) shifted in
// S_ARMED | permanent fault latched, TFEn rises on the next edge
// S_WAIT  | transient fault latched, timer counting towards the fire edge
// S_FIRE  | single-cycle pulse driven (mode 2)
// S_HOLD  | TFEn held high until DONE drops
// S_SPENT | window used up or frame rejected; waiting for DONE to drop
module sbtr_fault_rx #(
  parameter int SR_LEN = 8,
  parameter int TW     = 16
) (
  input logic           CLK,
  input logic           RST,
  sbtr_fault_rx_if.slave bus
);

  localparam int FRAME_LEN = 2 + TW + SR_LEN;
  localparam int CW        = $clog2(FRAME_LEN + 2);
  localparam logic [CW-1:0] CNT_FULL = CW'(FRAME_LEN);
  localparam logic [CW-1:0] CNT_SAT  = CW'(FRAME_LEN + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SHIFT, S_ARMED, S_WAIT, S_FIRE, S_HOLD, S_SPENT
  } state_t;

  state_t                 state_q, state_d;
  logic [FRAME_LEN-1:0]   sr_q, sr_d;
  logic                   so_q, so_d;
  logic [1:0]             mode_q, mode_d;
  logic [SR_LEN-1:0]      mask_q, mask_d;
  logic [TW-1:0]          tout_q, tout_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   tfen_q, tfen_d;
  logic                   err_q, err_d;

  logic [1:0]             f_mode;
  logic [TW-1:0]          f_tout;
  logic [SR_LEN-1:0]      f_mask;
  logic [TW-1:0]          timer_inc;
  logic [TW:0]            timer_p2;
  logic                   in_inj;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    so_d    = so_q;
    mode_d  = mode_q;
    mask_d  = mask_q;
    tout_d  = tout_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    tfen_d  = 1'b0;
    err_d   = err_q;

    f_mode    = sr_q[FRAME_LEN-1:FRAME_LEN-2];
    f_tout    = sr_q[FRAME_LEN-3:SR_LEN];
    f_mask    = sr_q[SR_LEN-1:0];
    timer_inc = (timer_q == tout_q) ? timer_q : timer_q + TW'(1);
    // Fire when the post-edge timer equals timeout-1, i.e. DONE edge number == timeout.
    timer_p2  = {1'b0, timer_q} + (TW+1)'(2);
    in_inj    = state_q inside {S_ARMED, S_WAIT, S_FIRE, S_HOLD, S_SPENT};

    if (bus.EN) begin
      sr_d    = {sr_q[FRAME_LEN-2:0], bus.SI};
      so_d    = sr_q[FRAME_LEN-1];
      state_d = S_SHIFT;
      if (in_inj)              cnt_d = CW'(1);
      else if (cnt_q != CNT_SAT) cnt_d = cnt_q + CW'(1);
      if (bus.DONE) err_d = 1'b1;
    end else if (bus.DONE) begin
      case (state_q)
        S_IDLE, S_SHIFT: begin
          if (cnt_q == CNT_FULL) begin
            mode_d  = f_mode;
            mask_d  = f_mask;
            tout_d  = f_tout;
            timer_d = '0;
            if (!f_mode[1]) begin
              state_d = S_ARMED;
            end else if (f_tout == '0) begin
              err_d   = 1'b1;
              state_d = S_SPENT;
            end else if (f_tout == TW'(1)) begin
              tfen_d  = 1'b1;
              state_d = f_mode[0] ? S_HOLD : S_FIRE;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            err_d   = 1'b1;
            state_d = S_SPENT;
          end
        end
        S_ARMED: begin
          tfen_d  = 1'b1;
          state_d = S_HOLD;
        end
        S_WAIT: begin
          timer_d = timer_inc;
          if (timer_p2 == {1'b0, tout_q}) begin
            tfen_d  = 1'b1;
            state_d = mode_q[0] ? S_HOLD : S_FIRE;
          end
        end
        S_FIRE: begin
          timer_d = timer_inc;
          state_d = S_SPENT;
        end
        S_HOLD: begin
          timer_d = timer_inc;
          tfen_d  = 1'b1;
        end
        S_SPENT: timer_d = timer_inc;
        default: state_d = S_IDLE;
      endcase
    end else if (in_inj) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      so_q    <= 1'b0;
      mode_q  <= '0;
      mask_q  <= '0;
      tout_q  <= '0;
      timer_q <= '0;
      cnt_q   <= '0;
      tfen_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      so_q    <= so_d;
      mode_q  <= mode_d;
      mask_q  <= mask_d;
      tout_q  <= tout_d;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      tfen_q  <= tfen_d;
      err_q   <= err_d;
    end
  end

  assign bus.SO      = so_q;
  assign bus.FI_MODE = mode_q;
  assign bus.FMASK   = mask_q;
  assign bus.TFEn    = tfen_q;
  assign bus.ERR     = err_q;

endmodule
